uart_tx_ctrl: RTL and testbench

Frame sequencer for the UART transmitter. It accepts a byte-valid request and steps the TX output mux through start, data, optional parity and stop phases. It also drives the serializer shift-enable and the data-load strobe. The block sits between the upstream data source and the serializer / parity-calc / output-mux datapath. One bit period equals one CLK cycle.

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_tx_ctrl.sv | 93 +++++++++
 tb/tb_uart_tx_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared codes for the UART transmit path: output-mux selects and the
// frame-sequencer state encoding.
package uart_tx_pkg;

   localparam logic [1:0] MUX_STOP  = 2'b00;
   localparam logic [1:0] MUX_START = 2'b01;
   localparam logic [1:0] MUX_DATA  = 2'b10;
   localparam logic [1:0] MUX_PAR   = 2'b11;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: walks the output mux through start, data,
// optional parity and stop phases, one bit period per CLK cycle.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | line idle (stop level), waiting for Data_Valid
//   ST_START  | start bit, one cycle
//   ST_DATA   | DATA_WIDTH data bits, serializer shifting
//   ST_PARITY | parity bit, only when parity was enabled at accept
//   ST_STOP   | STOP_BITS stop periods; last one may accept the next byte
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Data_Valid,
   input  logic       PAR_EN,
   output logic       data_load,
   output logic       ser_en,
   output logic [1:0] mux_sel,
   output logic       busy
);

   localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);
   localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [3:0] bit_cnt;
   logic       stop_cnt;
   logic       par_en_q;
   logic       stop_last;
   logic       accept;

   assign stop_last = (stop_cnt == STOP_LAST);

   // Gated by RST so a request during reset is never strobed into the datapath.
   assign accept    = RST & Data_Valid &
                      ((state == ST_IDLE) | ((state == ST_STOP) & stop_last));
   assign data_load = accept;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept) state_nxt = ST_START;
         ST_START:  state_nxt = ST_DATA;
         ST_DATA:   if (bit_cnt == DATA_LAST)
                       state_nxt = par_en_q ? ST_PARITY : ST_STOP;
         ST_PARITY: state_nxt = ST_STOP;
         ST_STOP:   if (stop_last)
                       state_nxt = accept ? ST_START : ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept)
            par_en_q <= PAR_EN;
         if ((state == ST_DATA) && (bit_cnt != DATA_LAST))
            bit_cnt <= bit_cnt + 4'd1;
         else
            bit_cnt <= '0;
         if ((state == ST_STOP) && !stop_last)
            stop_cnt <= stop_cnt + 1'b1;
         else
            stop_cnt <= 1'b0;
      end
   end

   always_comb begin
      mux_sel = MUX_STOP;
      ser_en  = 1'b0;
      busy    = 1'b0;
      case (state)
         ST_START:  begin mux_sel = MUX_START; busy = 1'b1; end
         ST_DATA:   begin mux_sel = MUX_DATA;  busy = 1'b1; ser_en = 1'b1; end
         ST_PARITY: begin mux_sel = MUX_PAR;   busy = 1'b1; end
         ST_STOP:   begin mux_sel = MUX_STOP;  busy = 1'b1; end
         default:   begin mux_sel = MUX_STOP;  busy = 1'b0; end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: two instances (8 data/1 stop and
// 5 data/2 stop) driven by directed cycle vectors.
module tb_uart_tx_ctrl;

   // Expected output vector layout: {data_load, ser_en, busy, mux_sel[1:0]}
   localparam logic [4:0] E_IDLE  = 5'b00000;
   localparam logic [4:0] E_LOAD  = 5'b10000;
   localparam logic [4:0] E_START = 5'b00101;
   localparam logic [4:0] E_DATA  = 5'b01110;
   localparam logic [4:0] E_PAR   = 5'b00111;
   localparam logic [4:0] E_STOP  = 5'b00100;
   localparam logic [4:0] E_STOPL = 5'b10100;

   typedef struct {
      logic       dut_sel;
      logic [4:0] exp;
      string      nm;
   } exp_t;

   exp_t sbq[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b0, dv_a = 1'b0, pe_a = 1'b0;
   logic       rst_b = 1'b0, dv_b = 1'b0, pe_b = 1'b0;
   logic       load_a, ser_a, busy_a, load_b, ser_b, busy_b;
   logic [1:0] mux_a, mux_b;
   logic       sel = 1'b0;
   logic       stim_done = 1'b0;

   int checks = 0;
   int errors = 0;

   uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
      .CLK(clk), .RST(rst_a), .Data_Valid(dv_a), .PAR_EN(pe_a),
      .data_load(load_a), .ser_en(ser_a), .mux_sel(mux_a), .busy(busy_a));

   uart_tx_ctrl #(.DATA_WIDTH(5), .STOP_BITS(2)) dut_b (
      .CLK(clk), .RST(rst_b), .Data_Valid(dv_b), .PAR_EN(pe_b),
      .data_load(load_b), .ser_en(ser_b), .mux_sel(mux_b), .busy(busy_b));

   // One bit period: drive inputs just after the edge, queue what the
   // selected instance must show at the following falling edge.
   task automatic cyc(input logic rst, input logic dv, input logic pe,
                      input logic [4:0] exp, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      if (sel) begin rst_b = rst; dv_b = dv; pe_b = pe; end
      else     begin rst_a = rst; dv_a = dv; pe_a = pe; end
      e.dut_sel = sel;
      e.exp     = exp;
      e.nm      = nm;
      sbq.push_back(e);
   endtask

   // Monitor: compares whenever an expectation is pending
   initial begin
      exp_t       e;
      logic [4:0] act;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = e.dut_sel ? {load_b, ser_b, busy_b, mux_b}
                            : {load_a, ser_a, busy_a, mux_a};
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s dut=%0d got={load,ser,busy,mux}=%b want=%b t=%0t",
                        e.nm, e.dut_sel, act, e.exp, $time);
            end
         end
      end
   end

   initial begin
      // 1: reset held with a request pending
      sel = 1'b0;
      cyc(1'b0, 1'b1, 1'b0, E_IDLE, "rst_hold0");
      cyc(1'b0, 1'b1, 1'b0, E_IDLE, "rst_hold1");
      cyc(1'b1, 1'b0, 1'b0, E_IDLE, "rst_release");

      // 2: single frame, no parity
      cyc(1'b1, 1'b1, 1'b0, E_LOAD,  "f1_accept");
      cyc(1'b1, 1'b0, 1'b0, E_START, "f1_start");
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, E_DATA, "f1_data");
      cyc(1'b1, 1'b0, 1'b0, E_STOP,  "f1_stop");
      cyc(1'b1, 1'b0, 1'b0, E_IDLE,  "f1_idle");

      // 3: parity latched at accept, PAR_EN dropped afterwards
      cyc(1'b1, 1'b1, 1'b1, E_LOAD,  "f2_accept");
      cyc(1'b1, 1'b0, 1'b0, E_START, "f2_start");
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, E_DATA, "f2_data");
      cyc(1'b1, 1'b0, 1'b0, E_PAR,   "f2_parity");
      cyc(1'b1, 1'b0, 1'b0, E_STOP,  "f2_stop");
      cyc(1'b1, 1'b0, 1'b0, E_IDLE,  "f2_idle");

      // 4: back-to-back with Data_Valid held high
      cyc(1'b1, 1'b1, 1'b0, E_LOAD,  "b2b_accept0");
      cyc(1'b1, 1'b1, 1'b0, E_START, "b2b_start0");
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, E_DATA, "b2b_data0");
      cyc(1'b1, 1'b1, 1'b0, E_STOPL, "b2b_stop_accept");
      cyc(1'b1, 1'b0, 1'b0, E_START, "b2b_start1");
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, E_DATA, "b2b_data1");
      cyc(1'b1, 1'b0, 1'b0, E_STOP,  "b2b_stop1");
      cyc(1'b1, 1'b0, 1'b0, E_IDLE,  "b2b_idle");

      // 5: request pulse mid-DATA is ignored
      cyc(1'b1, 1'b1, 1'b0, E_LOAD,  "ign_accept");
      cyc(1'b1, 1'b0, 1'b0, E_START, "ign_start");
      for (int i = 0; i < 8; i++)
         cyc(1'b1, (i == 3), 1'b1, E_DATA, "ign_data");
      cyc(1'b1, 1'b0, 1'b0, E_STOP,  "ign_stop");
      cyc(1'b1, 1'b0, 1'b0, E_IDLE,  "ign_idle");

      // 6: reset mid-DATA, then a full frame
      cyc(1'b1, 1'b1, 1'b0, E_LOAD,  "mr_accept");
      cyc(1'b1, 1'b0, 1'b0, E_START, "mr_start");
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, E_DATA, "mr_data");
      cyc(1'b0, 1'b1, 1'b0, E_DATA,  "mr_rst_cycle");
      cyc(1'b1, 1'b0, 1'b0, E_IDLE,  "mr_idle");
      cyc(1'b1, 1'b1, 1'b0, E_LOAD,  "mr2_accept");
      cyc(1'b1, 1'b0, 1'b0, E_START, "mr2_start");
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, E_DATA, "mr2_data");
      cyc(1'b1, 1'b0, 1'b0, E_STOP,  "mr2_stop");
      cyc(1'b1, 1'b0, 1'b0, E_IDLE,  "mr2_idle");

      // DATA_WIDTH=5, STOP_BITS=2 instance
      sel = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, E_IDLE,  "w5_rst");
      cyc(1'b1, 1'b0, 1'b0, E_IDLE,  "w5_release");
      cyc(1'b1, 1'b1, 1'b1, E_LOAD,  "w5_accept0");
      cyc(1'b1, 1'b0, 1'b0, E_START, "w5_start0");
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, E_DATA, "w5_data0");
      cyc(1'b1, 1'b1, 1'b0, E_PAR,   "w5_parity0");
      cyc(1'b1, 1'b1, 1'b0, E_STOP,  "w5_stop_first");
      cyc(1'b1, 1'b1, 1'b0, E_STOPL, "w5_stop_last_accept");
      cyc(1'b1, 1'b0, 1'b0, E_START, "w5_start1");
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, E_DATA, "w5_data1");
      cyc(1'b1, 1'b0, 1'b0, E_STOP,  "w5_stop1a");
      cyc(1'b1, 1'b0, 1'b0, E_STOP,  "w5_stop1b");
      cyc(1'b1, 1'b0, 1'b0, E_IDLE,  "w5_idle");
      // reset on the last stop cycle suppresses the back-to-back accept
      cyc(1'b1, 1'b1, 1'b0, E_LOAD,  "w5_accept2");
      cyc(1'b1, 1'b0, 1'b0, E_START, "w5_start2");
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, E_DATA, "w5_data2");
      cyc(1'b1, 1'b0, 1'b0, E_STOP,  "w5_stop2a");
      cyc(1'b0, 1'b1, 1'b0, E_STOP,  "w5_stop2b_rst");
      cyc(1'b1, 1'b0, 1'b0, E_IDLE,  "w5_idle2");

      @(posedge clk);
      stim_done = 1'b1;
   end

   initial begin
      int guard;
      guard = 0;
      while (!stim_done && guard < 2000) begin
         @(posedge clk);
         guard++;
      end
      repeat (3) @(posedge clk);
      if (!stim_done) begin
         errors++;
         $display("FAIL timeout got=stim_done=0 want=1");
      end
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d pending want=0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
